// File: rtl/cs_rx_collector.sv
`default_nettype none
// ============================================================================
//  Module   : cs_rx_collector
//  Collects one codeword's tagged symbols, issues a single erasure-aware
//  decode request and returns the decoder result on a valid/ready port.
//  Revision : 1.0
// ============================================================================
module cs_rx_collector #(
   parameter int M       = 3,
   parameter int K       = 2,
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int IDX_W   = (M > 1) ? $clog2(M) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sym_valid,
   output logic                 sym_ready,
   input  logic [IDX_W-1:0]     sym_idx,
   input  logic [WIDTH-1:0]     sym_data,
   input  logic                 sym_last,
   output logic                 dec_valid_in,
   output logic [M-1:0]         dec_erasure,
   output logic [M*WIDTH-1:0]   dec_coded_in,
   input  logic                 dec_valid_out,
   input  logic                 dec_ok,
   input  logic [K*WIDTH-1:0]   dec_data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [K*WIDTH-1:0]   out_data,
   output logic                 out_ok,
   output logic [15:0]          frames_ok,
   output logic [15:0]          frames_fail
);

   localparam int               TMR_W      = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_DEC = 2'd2,
      ST_OUTPUT   = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [M-1:0]                recv_q, recv_d;
   logic [M-1:0][WIDTH-1:0]     sym_buf_q, sym_buf_d;
   logic [TMR_W-1:0]            timer_q, timer_d;
   logic [M-1:0]                erasure_q, erasure_d;
   logic [M-1:0][WIDTH-1:0]     coded_q, coded_d;
   logic [K*WIDTH-1:0]          out_data_q, out_data_d;
   logic                        out_ok_q, out_ok_d;
   logic [15:0]                 frames_ok_q, frames_ok_d;
   logic [15:0]                 frames_fail_q, frames_fail_d;

   logic                        accept;
   logic                        close;
   logic                        idx_in_range;

   assign idx_in_range = (32'(sym_idx) < M);

   always_comb begin
      state_d       = state_q;
      recv_d        = recv_q;
      sym_buf_d     = sym_buf_q;
      timer_d       = timer_q;
      erasure_d     = erasure_q;
      coded_d       = coded_q;
      out_data_d    = out_data_q;
      out_ok_d      = out_ok_q;
      frames_ok_d   = frames_ok_q;
      frames_fail_d = frames_fail_q;
      accept        = 1'b0;
      close         = 1'b0;
      sym_ready     = 1'b0;
      dec_valid_in  = 1'b0;
      out_valid     = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            sym_ready = 1'b1;
            accept    = sym_valid;
            if (accept) begin
               // Out-of-range beats carry no data but still restart the timer and may end the frame.
               if (idx_in_range) begin
                  recv_d[sym_idx]    = 1'b1;
                  sym_buf_d[sym_idx] = sym_data;
               end
               timer_d = '0;
               close   = (recv_d == {M{1'b1}}) || sym_last;
            end else if (recv_q != '0) begin
               if (timer_q == c_tmr_last) begin
                  close = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            if (close) begin
               state_d   = ST_ISSUE;
               erasure_d = ~recv_d;
               for (int i = 0; i < M; i++) begin
                  coded_d[i] = recv_d[i] ? sym_buf_d[i] : '0;
               end
            end
         end

         ST_ISSUE: begin
            dec_valid_in = 1'b1;
            state_d      = ST_WAIT_DEC;
         end

         ST_WAIT_DEC: begin
            if (dec_valid_out) begin
               out_data_d = dec_data_out;
               out_ok_d   = dec_ok;
               state_d    = ST_OUTPUT;
            end
         end

         ST_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (out_ok_q) begin
                  if (frames_ok_q != 16'hFFFF) frames_ok_d = frames_ok_q + 16'd1;
               end else begin
                  if (frames_fail_q != 16'hFFFF) frames_fail_d = frames_fail_q + 16'd1;
               end
               recv_d  = '0;
               timer_d = '0;
               state_d = ST_COLLECT;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_COLLECT;
         recv_q        <= '0;
         sym_buf_q     <= '0;
         timer_q       <= '0;
         erasure_q     <= '0;
         coded_q       <= '0;
         out_data_q    <= '0;
         out_ok_q      <= 1'b0;
         frames_ok_q   <= '0;
         frames_fail_q <= '0;
      end else begin
         state_q       <= state_d;
         recv_q        <= recv_d;
         sym_buf_q     <= sym_buf_d;
         timer_q       <= timer_d;
         erasure_q     <= erasure_d;
         coded_q       <= coded_d;
         out_data_q    <= out_data_d;
         out_ok_q      <= out_ok_d;
         frames_ok_q   <= frames_ok_d;
         frames_fail_q <= frames_fail_d;
      end
   end

   assign dec_erasure  = erasure_q;
   assign dec_coded_in = coded_q;
   assign out_data     = out_data_q;
   assign out_ok       = out_ok_q;
   assign frames_ok    = frames_ok_q;
   assign frames_fail  = frames_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_rx_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cs_rx_collector
//  Table-driven frame bench with a parity-code decoder model and scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_cs_rx_collector;

   localparam int M       = 3;
   localparam int K       = 2;
   localparam int WIDTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int NV      = 7;

   logic                clk;
   logic                rst;
   logic                sym_valid;
   logic                sym_ready;
   logic [1:0]          sym_idx;
   logic [WIDTH-1:0]    sym_data;
   logic                sym_last;
   logic                dec_valid_in;
   logic [M-1:0]        dec_erasure;
   logic [M*WIDTH-1:0]  dec_coded_in;
   logic                dec_valid_out;
   logic                dec_ok;
   logic [K*WIDTH-1:0]  dec_data_out;
   logic                out_valid;
   logic                out_ready;
   logic [K*WIDTH-1:0]  out_data;
   logic                out_ok;
   logic [15:0]         frames_ok;
   logic [15:0]         frames_fail;

   cs_rx_collector #(.M(M), .K(K), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .sym_valid     (sym_valid),
      .sym_ready     (sym_ready),
      .sym_idx       (sym_idx),
      .sym_data      (sym_data),
      .sym_last      (sym_last),
      .dec_valid_in  (dec_valid_in),
      .dec_erasure   (dec_erasure),
      .dec_coded_in  (dec_coded_in),
      .dec_valid_out (dec_valid_out),
      .dec_ok        (dec_ok),
      .dec_data_out  (dec_data_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_ok        (out_ok),
      .frames_ok     (frames_ok),
      .frames_fail   (frames_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       last;
      logic [1:0] idx;
      logic [3:0] dat;
   } beat_t;

   typedef struct {
      int          n;
      beat_t       beats[6];
      logic [2:0]  era;
      logic [11:0] coded;
      logic [7:0]  data;
      logic        ok;
      int          lat;
      int          rdelay;
   } vec_t;

   typedef struct packed {
      logic [2:0]  era;
      logic [11:0] coded;
      logic [7:0]  data;
      logic        ok;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[NV];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   dec_pulses = 0;
   int   exp_ok  = 0;
   int   exp_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic beat_t bt(input logic [1:0] idx, input logic [3:0] dat, input logic last);
      beat_t b;
      b.last = last;
      b.idx  = idx;
      b.dat  = dat;
      return b;
   endfunction

   task automatic drive_beat(input beat_t b);
      chk("sym_ready_beat", sym_ready, 1);
      sym_valid = 1'b1;
      sym_idx   = b.idx;
      sym_data  = b.dat;
      sym_last  = b.last;
      @(posedge clk); #1;
      sym_valid = 1'b0;
      sym_last  = 1'b0;
   endtask

   // Scoreboard monitor: decode requests and delivered results against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_ok   = 0;
            exp_fail = 0;
         end
         if (dec_valid_in) begin
            dec_pulses++;
            if (exp_q.size() == 0) chk("dec_req_unexpected", 32'(exp_q.size()), 1);
            else begin
               chk("dec_erasure", dec_erasure, exp_q[0].era);
               chk("dec_coded_in", dec_coded_in, exp_q[0].coded);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", 32'(exp_q.size()), 1);
            else begin
               chk("out_data", out_data, exp_q[0].data);
               chk("out_ok", out_ok, exp_q[0].ok);
               if (exp_q[0].ok) exp_ok++;
               else exp_fail++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Decoder model: single-parity (2,3) code, c2 = d0 ^ d1, corrects one erasure.
   logic [3:0] c0, c1, c2;
   int         ne;
   initial begin
      dec_valid_out = 1'b0;
      dec_ok        = 1'b0;
      dec_data_out  = '0;
      forever begin
         @(negedge clk);
         if (dec_valid_in) begin
            c0 = dec_coded_in[3:0];
            c1 = dec_coded_in[7:4];
            c2 = dec_coded_in[11:8];
            ne = int'(dec_erasure[0]) + int'(dec_erasure[1]) + int'(dec_erasure[2]);
            repeat (2) @(posedge clk);
            #1;
            dec_valid_out = 1'b1;
            if (ne > 1) begin
               dec_ok       = 1'b0;
               dec_data_out = '0;
            end else begin
               dec_ok       = 1'b1;
               dec_data_out = {(dec_erasure[1] ? (c0 ^ c2) : c1),
                               (dec_erasure[0] ? (c1 ^ c2) : c0)};
            end
            @(posedge clk); #1;
            dec_valid_out = 1'b0;
         end
      end
   end

   initial begin
      exp_t e;
      int   p0;
      int   n;

      rst       = 1'b1;
      sym_valid = 1'b0;
      sym_idx   = '0;
      sym_data  = '0;
      sym_last  = 1'b0;
      out_ready = 1'b0;

      // Clean frame d=(A,5), parity F
      vecs[0].n = 3; vecs[0].beats[0] = bt(2'd0, 4'hA, 1'b0); vecs[0].beats[1] = bt(2'd1, 4'h5, 1'b0);
      vecs[0].beats[2] = bt(2'd2, 4'hF, 1'b1);
      vecs[0].era = 3'b000; vecs[0].coded = 12'hF5A; vecs[0].data = 8'h5A; vecs[0].ok = 1'b1;
      vecs[0].lat = 0; vecs[0].rdelay = 0;
      // Out of order, position 1 missing
      vecs[1].n = 2; vecs[1].beats[0] = bt(2'd2, 4'hF, 1'b0); vecs[1].beats[1] = bt(2'd0, 4'hA, 1'b1);
      vecs[1].era = 3'b010; vecs[1].coded = 12'hF0A; vecs[1].data = 8'h5A; vecs[1].ok = 1'b1;
      vecs[1].lat = 0; vecs[1].rdelay = 0;
      // Timeout with only position 0
      vecs[2].n = 1; vecs[2].beats[0] = bt(2'd0, 4'hA, 1'b0);
      vecs[2].era = 3'b110; vecs[2].coded = 12'h00A; vecs[2].data = 8'h00; vecs[2].ok = 1'b0;
      vecs[2].lat = TIMEOUT; vecs[2].rdelay = 0;
      // Back-pressure, d=(3,9), parity A
      vecs[3].n = 3; vecs[3].beats[0] = bt(2'd0, 4'h3, 1'b0); vecs[3].beats[1] = bt(2'd1, 4'h9, 1'b0);
      vecs[3].beats[2] = bt(2'd2, 4'hA, 1'b1);
      vecs[3].era = 3'b000; vecs[3].coded = 12'hA93; vecs[3].data = 8'h93; vecs[3].ok = 1'b1;
      vecs[3].lat = 0; vecs[3].rdelay = 5;
      // Duplicate index and out-of-range index
      vecs[4].n = 5; vecs[4].beats[0] = bt(2'd1, 4'h3, 1'b0); vecs[4].beats[1] = bt(2'd1, 4'h7, 1'b0);
      vecs[4].beats[2] = bt(2'd3, 4'h9, 1'b0); vecs[4].beats[3] = bt(2'd0, 4'hA, 1'b0);
      vecs[4].beats[4] = bt(2'd2, 4'hF, 1'b0);
      vecs[4].era = 3'b000; vecs[4].coded = 12'hF7A; vecs[4].data = 8'h7A; vecs[4].ok = 1'b1;
      vecs[4].lat = 0; vecs[4].rdelay = 0;
      // Out-of-range first beat with last: everything erased
      vecs[5].n = 1; vecs[5].beats[0] = bt(2'd3, 4'h1, 1'b1);
      vecs[5].era = 3'b111; vecs[5].coded = 12'h000; vecs[5].data = 8'h00; vecs[5].ok = 1'b0;
      vecs[5].lat = 0; vecs[5].rdelay = 0;
      // Position 0 missing, d=(3,9)
      vecs[6].n = 2; vecs[6].beats[0] = bt(2'd1, 4'h9, 1'b0); vecs[6].beats[1] = bt(2'd2, 4'hA, 1'b1);
      vecs[6].era = 3'b001; vecs[6].coded = 12'hA90; vecs[6].data = 8'h93; vecs[6].ok = 1'b1;
      vecs[6].lat = 0; vecs[6].rdelay = 0;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_sym_ready", sym_ready, 1);
      chk("rst_dec_valid_in", dec_valid_in, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dec_erasure", dec_erasure, 0);
      chk("rst_dec_coded_in", dec_coded_in, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ok", out_ok, 0);
      chk("rst_frames_ok", frames_ok, 0);
      chk("rst_frames_fail", frames_fail, 0);

      // Reset in the middle of a frame must discard the partial frame.
      p0 = dec_pulses;
      drive_beat(bt(2'd0, 4'hA, 1'b0));
      drive_beat(bt(2'd1, 4'h5, 1'b0));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (TIMEOUT + 4) @(posedge clk);
      #1;
      chk("midrst_no_dec_req", 32'(dec_pulses - p0), 0);
      chk("midrst_sym_ready", sym_ready, 1);
      chk("midrst_frames_ok", frames_ok, 0);
      chk("midrst_frames_fail", frames_fail, 0);

      for (int v = 0; v < NV; v++) begin
         e.era   = vecs[v].era;
         e.coded = vecs[v].coded;
         e.data  = vecs[v].data;
         e.ok    = vecs[v].ok;
         exp_q.push_back(e);
         p0 = dec_pulses;
         for (int b = 0; b < vecs[v].n; b++) drive_beat(vecs[v].beats[b]);

         n = 0;
         while (!dec_valid_in && n < 64) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("close_lat[%0d]", v), 32'(n), 32'(vecs[v].lat));

         n = 0;
         while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("out_valid_seen[%0d]", v), out_valid, 1);

         for (int c = 0; c < vecs[v].rdelay; c++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, vecs[v].data);
            chk("bp_out_ok", out_ok, vecs[v].ok);
            chk("bp_sym_ready", sym_ready, 0);
            chk("bp_frames_ok", frames_ok, 32'(exp_ok));
            chk("bp_frames_fail", frames_fail, 32'(exp_fail));
         end

         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk($sformatf("post_out_valid[%0d]", v), out_valid, 0);
         chk($sformatf("post_sym_ready[%0d]", v), sym_ready, 1);
         chk($sformatf("frames_ok[%0d]", v), frames_ok, 32'(exp_ok));
         chk($sformatf("frames_fail[%0d]", v), frames_fail, 32'(exp_fail));
         chk($sformatf("dec_req_count[%0d]", v), 32'(dec_pulses - p0), 1);
      end

      chk("final_frames_ok", frames_ok, 5);
      chk("final_frames_fail", frames_fail, 2);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cs_rx_collector.md
Name: cs_rx_collector

Overview:
Receive-side front end for cs_codec's decoder port.
- Gathers the coded symbols of one codeword as they arrive one per beat, each tagged with its position.
- Builds the erasure mask from the positions that never arrived, then issues a single decode request.
- Captures the decoder result and presents it on a valid/ready output with pass/fail statistics.

Parameters:
M, 3, coded symbols per codeword (matches codec M)
K, 2, data symbols per codeword (matches codec K)
WIDTH, 4, bits per symbol (matches codec WIDTH)
TIMEOUT, 16, idle cycles after last accepted symbol before a partial frame is closed (>=1)
IDX_W, $clog2(M) (min 1), width of symbol index

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
sym_valid  input  1  upstream symbol valid
sym_ready  output  1  block can accept a symbol
sym_idx  input  IDX_W  codeword position of symbol
sym_data  input  WIDTH  symbol value
sym_last  input  1  sender marks final symbol of frame
dec_valid_in  output  1  one-cycle decode request to cs_codec
dec_erasure  output  M  bit i=1: position i missing
dec_coded_in  output  M x WIDTH  collected symbols, erased positions driven 0
dec_valid_out  input  1  decoder result strobe
dec_ok  input  1  decoder success flag
dec_data_out  input  K x WIDTH  decoded data
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  K x WIDTH  captured decoded data
out_ok  output  1  captured dec_ok
frames_ok  output  16  count of delivered frames with ok=1, saturating
frames_fail  output  16  count of delivered frames with ok=0, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset:
  - State goes to COLLECT.
  - Received mask, symbol buffer, timer, counters, out_data and out_ok all clear to 0.
  - dec_valid_in=0 and out_valid=0.
  - sym_ready goes to 1 on the first cycle after reset deasserts.
  - Reset asserted in any state, including mid-frame or while awaiting the decoder, discards everything.
  - A dec_valid_out arriving after reset is ignored (state is not WAIT_DEC).
- FSM states: COLLECT, ISSUE, WAIT_DEC, OUTPUT.
- COLLECT:
  - sym_ready=1; a symbol is accepted when sym_valid && sym_ready.
  - Accept with sym_idx<M: buf[idx]<=sym_data and recv[idx]<=1. A duplicate index overwrites the earlier value.
  - Accept with sym_idx>=M: data dropped, but the beat still counts for timer reset and for sym_last.
  - Timer runs only while recv!=0. It resets to 0 on every accepted beat and otherwise increments.
  - Close the frame on any of:
    - the accepted beat makes recv all-ones;
    - an accepted beat has sym_last=1;
    - the timer reaches TIMEOUT-1 with no beat accepted in that cycle.
  - A beat accepted in the closing cycle is included. Simultaneous close conditions produce a single close.
  - On close, go to ISSUE.
  - sym_last on the first beat with an out-of-range index closes a frame with all-ones erasure.
- ISSUE:
  - sym_ready=0; dec_valid_in=1 for exactly this one cycle.
  - dec_erasure=~recv; dec_coded_in[i]=recv[i]?buf[i]:0. Both are registered and held stable until the next ISSUE.
  - Next state WAIT_DEC.
- WAIT_DEC:
  - sym_ready=0; waits indefinitely for dec_valid_out.
  - On the strobe, capture out_data<=dec_data_out and out_ok<=dec_ok, then go to OUTPUT.
- OUTPUT:
  - out_valid=1, with out_data and out_ok held until out_ready.
  - On the handshake cycle:
    - increment frames_ok or frames_fail (saturate at 0xFFFF);
    - clear recv and timer;
    - go to COLLECT, with out_valid=0 on the next cycle.
  - No symbol is accepted in OUTPUT.
- Latency: frame close to dec_valid_in is 1 cycle. Decoder strobe to out_valid is 1 cycle.
- Throughput: one codeword in flight; upstream is back-pressured via sym_ready.

Test Plan:
1. (2,3) clean frame: symbols idx0,1,2 encoded from d=(0xA,0x5), last on idx2 -> one dec_valid_in pulse with dec_erasure=000; out_data=(0xA,0x5), out_ok=1, frames_ok=1.
2. Out-of-order with missing position: idx2, then idx0 with sym_last -> dec_erasure=010, dec_coded_in[1]=0; out_data=(0xA,0x5), out_ok=1.
3. Timeout with TIMEOUT=16: idx0 only, then idle -> frame closes 16 cycles after the accept; dec_erasure=110, out_ok=0, frames_fail=1.
4. Back-pressure: out_ready low for 5 cycles in OUTPUT -> out_valid and out_data stable, sym_ready=0, no counter change; counter increments once out_ready rises.
5. Duplicate/out-of-range: idx1=0x3, idx1=0x7, idx3 (>=M), idx0, idx2 -> buf[1]=0x7, dec_erasure=000, exactly one decode request.
6. Reset mid-frame: rst after 2 symbols -> recv cleared, no dec_valid_in. A following clean frame decodes correctly, with frames_ok=1 and frames_fail=0.
